// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  // Size 2'b11 falls into the default arm and is handled as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the EX request, data-memory and WB result channels of the controller.
// The controller takes the slave view; the surrounding pipeline/memory take the master view.
interface lsu_mem_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_misalign;
  logic        out_buserr;
  logic [31:0] out_badaddr;

  modport slave (
    input  in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output out_valid, out_rdata, out_rd, out_misalign, out_buserr, out_badaddr,
    input  out_ready
  );

  modport master (
    output in_valid, in_is_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_valid, out_rdata, out_rd, out_misalign, out_buserr, out_badaddr,
    output out_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/replicated data from the incoming
// request, and load extraction with sign/zero extension from the raw memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_mask = 4'b1111;
    st_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_mask = 4'b0001 << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_mask = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    shifted = ld_raw >> {ld_addr_lo, 3'b000};
    ld_data = ld_raw;
    case (ld_size)
      SZ_B: ld_data = ld_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between EX and the data-memory port: one outstanding
// transaction, registered request and result, timeout-forced bus error.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic        is_store;
  logic        ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic [7:0]  cnt;

  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  // Store lanes come from the live request (registered at capture); load
  // extraction uses the captured fields since in_* may change after the handshake.
  lsu_align u_align (
    .st_size     (bus.in_size),
    .st_addr_lo  (bus.in_addr[1:0]),
    .st_wdata    (bus.in_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (size),
    .ld_unsigned (ld_unsigned),
    .ld_addr_lo  (addr[1:0]),
    .ld_raw      (bus.mem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      is_store          <= 1'b0;
      ld_unsigned       <= 1'b0;
      size              <= SZ_B;
      addr              <= 32'b0;
      rd                <= 5'b0;
      cnt               <= 8'b0;
      bus.in_ready      <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= 32'b0;
      bus.mem_wmask     <= 4'b0;
      bus.mem_wdata     <= 32'b0;
      bus.out_valid     <= 1'b0;
      bus.out_rdata     <= 32'b0;
      bus.out_rd        <= 5'b0;
      bus.out_misalign  <= 1'b0;
      bus.out_buserr    <= 1'b0;
      bus.out_badaddr   <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            is_store     <= bus.in_is_store;
            ld_unsigned  <= bus.in_unsigned;
            size         <= bus.in_size;
            addr         <= bus.in_addr;
            rd           <= bus.in_rd;
            bus.in_ready <= 1'b0;
            if (misaligned(bus.in_size, bus.in_addr[1:0])) begin
              state            <= S_RESP;
              bus.out_valid    <= 1'b1;
              bus.out_misalign <= 1'b1;
              bus.out_badaddr  <= bus.in_addr;
              bus.out_rd       <= bus.in_rd;
              bus.out_rdata    <= 32'b0;
            end else begin
              state             <= S_REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_we        <= bus.in_is_store;
              bus.mem_addr      <= {bus.in_addr[31:2], 2'b00};
              bus.mem_wmask     <= bus.in_is_store ? st_mask : 4'b0;
              bus.mem_wdata     <= bus.in_is_store ? st_data : 32'b0;
            end
          end
        end

        S_REQ: begin
          if (bus.mem_req_ready) begin
            state             <= S_WAIT;
            cnt               <= 8'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= 32'b0;
            bus.mem_wmask     <= 4'b0;
            bus.mem_wdata     <= 32'b0;
          end
        end

        // A response arriving on the timeout cycle takes priority over the bus error.
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            state         <= S_RESP;
            bus.out_valid <= 1'b1;
            bus.out_rdata <= is_store ? 32'b0 : ld_data;
            bus.out_rd    <= rd;
          end else if (cnt == TIMEOUT_CNT) begin
            state           <= S_RESP;
            bus.out_valid   <= 1'b1;
            bus.out_buserr  <= 1'b1;
            bus.out_badaddr <= addr;
            bus.out_rd      <= rd;
            bus.out_rdata   <= 32'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_RESP: begin
          if (bus.out_ready) begin
            state            <= S_IDLE;
            bus.in_ready     <= 1'b1;
            bus.out_valid    <= 1'b0;
            bus.out_rdata    <= 32'b0;
            bus.out_rd       <= 5'b0;
            bus.out_misalign <= 1'b0;
            bus.out_buserr   <= 1'b0;
            bus.out_badaddr  <= 32'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed transactions, a transaction-level
// expectation model, and a per-cycle compare process on the falling clock edge.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  bit          busy   = 1'b0;
  bit          req_on = 1'b0;
  bit          res_on = 1'b0;
  logic [31:0] e_addr, e_wdata, e_rdata, e_badaddr;
  logic [3:0]  e_mask;
  logic        e_we, e_mis, e_berr;
  logic [4:0]  e_rd;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m = 4'b0;
    int off = int'(a[1:0]);
    for (int i = 0; i < nbytes(sz); i++) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = w[8*(i % nbytes(sz)) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] raw);
    int n = nbytes(sz);
    logic [31:0] lim, v;
    if (n == 4) return raw;
    lim = (32'd1 << (8*n)) - 32'd1;
    v = (raw >> (8*int'(a[1:0]))) & lim;
    if (!uns && v[8*n-1]) v = v | ~lim;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-cycle comparison against the expected protocol phase and transaction fields.
  always @(negedge clock) begin
    checkOutput("in_ready", 32'(bus.in_ready), 32'(!busy));
    checkOutput("mem_req_valid", 32'(bus.mem_req_valid), 32'(req_on));
    if (req_on && bus.mem_req_valid) begin
      checkOutput("mem_addr", bus.mem_addr, e_addr);
      checkOutput("mem_we", 32'(bus.mem_we), 32'(e_we));
      checkOutput("mem_wmask", 32'(bus.mem_wmask), 32'(e_mask));
      if (e_we) checkOutput("mem_wdata", bus.mem_wdata, e_wdata);
    end
    checkOutput("out_valid", 32'(bus.out_valid), 32'(res_on));
    if (res_on && bus.out_valid) begin
      checkOutput("out_rdata", bus.out_rdata, e_rdata);
      checkOutput("out_rd", 32'(bus.out_rd), 32'(e_rd));
      checkOutput("out_misalign", 32'(bus.out_misalign), 32'(e_mis));
      checkOutput("out_buserr", 32'(bus.out_buserr), 32'(e_berr));
      checkOutput("out_badaddr", bus.out_badaddr, e_badaddr);
    end
  end

  // resp_delay < 0 means memory never answers.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input int req_stall, input int resp_delay,
                               input logic [31:0] raw, input int out_stall);
    bit mis = model_mis(sz, addr);
    e_addr    = {addr[31:2], 2'b00};
    e_we      = st;
    e_mask    = st ? model_mask(sz, addr) : 4'b0;
    e_wdata   = model_wdata(sz, wdata);
    e_rd      = rd;
    e_mis     = mis;
    e_berr    = !mis && (resp_delay < 0);
    e_rdata   = (mis || st || resp_delay < 0) ? 32'b0 : model_load(sz, uns, addr, raw);
    e_badaddr = (mis || resp_delay < 0) ? addr : 32'b0;

    tick();
    bus.in_valid    = 1'b1;
    bus.in_is_store = st;
    bus.in_size     = sz;
    bus.in_unsigned = uns;
    bus.in_addr     = addr;
    bus.in_wdata    = wdata;
    bus.in_rd       = rd;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_is_store = ~st;
    bus.in_size     = ~sz;
    bus.in_unsigned = ~uns;
    bus.in_addr     = ~addr;
    bus.in_wdata    = ~wdata;
    bus.in_rd       = ~rd;
    busy = 1'b1;
    if (mis) begin
      res_on = 1'b1;
    end else begin
      req_on = 1'b1;
      repeat (req_stall) tick();
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      req_on = 1'b0;
      if (resp_delay >= 0) begin
        repeat (resp_delay) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = raw;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h5A5A_5A5A;
      end else begin
        repeat (TIMEOUT + 1) tick();
      end
      res_on = 1'b1;
    end
    for (int i = 0; i < out_stall; i++) begin
      bus.mem_resp_valid = (i == 0);
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    res_on = 1'b0;
    busy   = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_is_store = 1'b0; bus.in_size = 2'b00; bus.in_unsigned = 1'b0;
    bus.in_addr = 32'b0; bus.in_wdata = 32'b0; bus.in_rd = 5'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'b0;
    bus.out_ready = 1'b0;

    // Pin the model with hand-computed values.
    checkOutput("model_sb_mask", 32'(model_mask(2'b00, 32'h8000_0003)), 32'h8);
    checkOutput("model_sb_data", model_wdata(2'b00, 32'h1234_56AB), 32'hABAB_ABAB);
    checkOutput("model_sh_mask", 32'(model_mask(2'b01, 32'h1000_0002)), 32'hC);
    checkOutput("model_lb", model_load(2'b00, 1'b0, 32'h8000_0001, 32'h0000_8000), 32'hFFFF_FF80);
    checkOutput("model_lbu", model_load(2'b00, 1'b1, 32'h8000_0001, 32'h0000_8000), 32'h0000_0080);
    checkOutput("model_lh", model_load(2'b01, 1'b0, 32'h8000_0002, 32'h8001_1234), 32'hFFFF_8001);

    tick(); tick();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    checkOutput("rst_out_badaddr", bus.out_badaddr, 32'd0);
    reset = 1'b0;

    //            st    sz     uns   addr          wdata         rd     rqs rsp  raw           os
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h1234_56AB, 5'd3,  0, 1,  32'h0,        0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h8000_0001, 32'h0,        5'd4,  0, 0,  32'h0000_8000, 0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h8000_0001, 32'h0,        5'd5,  0, 2,  32'h0000_8000, 1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0,        5'd6,  0, 0,  32'h0,        0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0,        5'd7,  3, 2,  32'h8001_1234, 2);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,        5'd8,  1, 0,  32'h1234_F00D, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'hCAFE_BEEF, 5'd9,  0, 3,  32'h0,        0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 5'd10, 2, 0,  32'h0,        0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        5'd11, 0, 0,  32'h0,        1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,        5'd12, 0, 1,  32'h8765_4321, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'h0,        5'd13, 0, -1, 32'h0,        0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4000_0014, 32'h0,        5'd14, 0, TIMEOUT, 32'h1357_9BDF, 0);

    // Reset while waiting for a response drops the op; stale response afterwards is ignored.
    e_addr = 32'h2000_0000; e_we = 1'b0; e_mask = 4'b0;
    tick();
    bus.in_valid = 1'b1; bus.in_is_store = 1'b0; bus.in_size = 2'b10; bus.in_addr = 32'h2000_0000;
    tick();
    bus.in_valid = 1'b0; busy = 1'b1; req_on = 1'b1;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0; req_on = 1'b0;
    repeat (5) tick();
    reset = 1'b1; busy = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_resp_valid = 1'b0;
    repeat (3) tick();
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 5'd15, 0, 0, 32'h00F0_0000, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
